// File: rtl/apb_pkg.sv
// Shared types and constants for the two-requester APB master.
package apb_pkg;

   localparam int DATA_W           = 8;
   localparam int ADDR_W           = 32;
   localparam int MAX_ADDR_DEFAULT = 15;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } apb_state_e;

   // Turn a requester index into its one-hot completion pattern.
   function automatic logic [1:0] grant_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves only when a grant is taken.
module rr_arb2 (
   input  logic       pclk,
   input  logic       presetn,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   logic prio_one;

   // A lone request always wins; on a tie the requester not served last wins.
   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = prio_one ? 2'b10 : 2'b01;
      end
   end

   // After serving requester 0, requester 1 gets priority next, and vice versa.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         prio_one <= 1'b0;
      end else if (advance && (|gnt)) begin
         prio_one <= gnt[0];
      end
   end

endmodule

// File: rtl/apb_arb_master.sv
// APB master shared by two requesters: arbitrate, run one SETUP/ACCESS
// transfer, report completion with a one-cycle req_done pulse.
module apb_arb_master #(
   parameter int TIMEOUT_CYC = 16,
   parameter int MAX_ADDR    = apb_pkg::MAX_ADDR_DEFAULT
) (
   input  logic                            pclk,
   input  logic                            presetn,
   input  logic [1:0]                      req_valid,
   input  logic [1:0]                      req_write,
   input  logic [2*apb_pkg::ADDR_W-1:0]    req_addr,
   input  logic [2*apb_pkg::DATA_W-1:0]    req_wdata,
   output logic [1:0]                      req_done,
   output logic [apb_pkg::DATA_W-1:0]      req_rdata,
   output logic                            req_err,
   output logic                            psel,
   output logic                            penable,
   output logic                            pwrite,
   output logic [apb_pkg::ADDR_W-1:0]      paddr,
   output logic [apb_pkg::DATA_W-1:0]      pwdata,
   input  logic [apb_pkg::DATA_W-1:0]      prdata,
   input  logic                            pready,
   input  logic                            pslverr
);

   import apb_pkg::*;

   localparam int                 CNT_W      = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(TIMEOUT_CYC);
   localparam logic [ADDR_W-1:0]  ADDR_LIMIT = ADDR_W'(MAX_ADDR);

   apb_state_e          state, state_n;
   logic [CNT_W-1:0]    cnt, cnt_n;
   logic                gnt_idx, gnt_idx_n;
   logic                psel_n, penable_n, pwrite_n;
   logic [ADDR_W-1:0]   paddr_n;
   logic [DATA_W-1:0]   pwdata_n;
   logic [1:0]          req_done_n;
   logic [DATA_W-1:0]   req_rdata_n;
   logic                req_err_n;

   logic [1:0]          gnt;
   logic                advance;
   logic                sel;
   logic                sel_write;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;

   assign advance = (state == IDLE) && (|req_valid);

   rr_arb2 u_arb (
      .pclk    (pclk),
      .presetn (presetn),
      .req     (req_valid),
      .advance (advance),
      .gnt     (gnt)
   );

   // Pick out the winning requester's direction, address and write data.
   always_comb begin
      sel       = gnt[1];
      sel_write = sel ? req_write[1] : req_write[0];
      sel_addr  = sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
      sel_wdata = sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
   end

   // Next state plus the next value of every registered output.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      gnt_idx_n   = gnt_idx;
      psel_n      = 1'b0;
      penable_n   = 1'b0;
      pwrite_n    = pwrite;
      paddr_n     = paddr;
      pwdata_n    = pwdata;
      req_done_n  = 2'b00;
      req_rdata_n = req_rdata;
      req_err_n   = req_err;

      case (state)
         IDLE: begin
            cnt_n = '0;
            if (|req_valid) begin
               gnt_idx_n = sel;
               pwrite_n  = sel_write;
               paddr_n   = sel_addr;
               pwdata_n  = sel_wdata;
               if (sel_addr > ADDR_LIMIT) begin
                  state_n     = DONE;
                  req_done_n  = grant_onehot(sel);
                  req_rdata_n = '0;
                  req_err_n   = 1'b1;
               end else begin
                  state_n = SETUP;
                  psel_n  = 1'b1;
               end
            end
         end

         SETUP: begin
            state_n   = ACCESS;
            psel_n    = 1'b1;
            penable_n = 1'b1;
            cnt_n     = CNT_W'(1);
         end

         ACCESS: begin
            if (pready) begin
               state_n     = DONE;
               req_done_n  = grant_onehot(gnt_idx);
               req_err_n   = pslverr;
               req_rdata_n = pwrite ? '0 : prdata;
               cnt_n       = '0;
            end else if (cnt == CNT_MAX) begin
               state_n     = DONE;
               req_done_n  = grant_onehot(gnt_idx);
               req_err_n   = 1'b1;
               req_rdata_n = '0;
               cnt_n       = '0;
            end else begin
               psel_n    = 1'b1;
               penable_n = 1'b1;
               cnt_n     = cnt + CNT_W'(1);
            end
         end

         DONE: begin
            state_n = IDLE;
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Register state and all outputs; reset drops any transfer in flight.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state     <= IDLE;
         cnt       <= '0;
         gnt_idx   <= 1'b0;
         psel      <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         req_done  <= 2'b00;
         req_rdata <= '0;
         req_err   <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         gnt_idx   <= gnt_idx_n;
         psel      <= psel_n;
         penable   <= penable_n;
         pwrite    <= pwrite_n;
         paddr     <= paddr_n;
         pwdata    <= pwdata_n;
         req_done  <= req_done_n;
         req_rdata <= req_rdata_n;
         req_err   <= req_err_n;
      end
   end

endmodule

// File: tb/tb_apb_arb_master.sv
// Scoreboard bench for apb_arb_master: directed scenarios plus random traffic
// against a transaction-level model of the slave memory.
module tb_apb_arb_master;

   import apb_pkg::*;

   localparam int TIMEOUT = 16;
   localparam int MAXA    = 15;

   typedef struct packed {
      logic [1:0] done;
      logic [7:0] rdata;
      logic       err;
   } resp_t;

   logic        pclk;
   logic        presetn;
   logic [1:0]  req_valid;
   logic [1:0]  req_write;
   logic [63:0] req_addr;
   logic [15:0] req_wdata;
   logic [1:0]  req_done;
   logic [7:0]  req_rdata;
   logic        req_err;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [7:0]  pwdata;
   logic [7:0]  prdata;
   logic        pready;
   logic        pslverr;

   resp_t       exp_q[$];
   int          tests = 0;
   int          fails = 0;
   logic [7:0]  ref_mem[16];
   logic [7:0]  slave_mem[16];
   int          plan_wait = 0;
   logic        plan_err = 1'b0;
   int          acc_cnt = 0;

   apb_arb_master #(
      .TIMEOUT_CYC (TIMEOUT),
      .MAX_ADDR    (MAXA)
   ) dut (
      .pclk      (pclk),
      .presetn   (presetn),
      .req_valid (req_valid),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_done  (req_done),
      .req_rdata (req_rdata),
      .req_err   (req_err),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr)
   );

   // Free-running 10-unit clock.
   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // Safety net in case something stalls beyond every local bound.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Transaction-level prediction: illegal address or a slave slower than the
   // timeout gives an error with zero data; otherwise reads return memory
   // contents and writes land unless the slave flags an error.
   function automatic resp_t predict(input int r, input bit wr, input logic [31:0] addr,
                                     input logic [7:0] wd, input int wt, input bit se);
      resp_t e;
      e.done = (r == 0) ? 2'b01 : 2'b10;
      if ((addr > 32'(MAXA)) || (wt >= TIMEOUT)) begin
         e.err   = 1'b1;
         e.rdata = 8'h00;
      end else begin
         e.err   = se;
         e.rdata = wr ? 8'h00 : ref_mem[addr[3:0]];
         if (wr && !se) ref_mem[addr[3:0]] = wd;
      end
      return e;
   endfunction

   // Slave: raise pready after plan_wait stalled ACCESS cycles, serve memory.
   always @(negedge pclk) begin
      if (psel && penable) begin
         if (acc_cnt == plan_wait) begin
            pready  = 1'b1;
            pslverr = plan_err;
            prdata  = pwrite ? 8'($urandom) : slave_mem[paddr[3:0]];
            if (pwrite && !plan_err) slave_mem[paddr[3:0]] = pwdata;
         end else begin
            pready  = 1'b0;
            pslverr = 1'b0;
            prdata  = 8'($urandom);
         end
         acc_cnt++;
      end else begin
         pready  = 1'b0;
         pslverr = 1'b0;
         acc_cnt = 0;
      end
   end

   // Monitor: pop the expected response whenever req_done fires.
   always @(negedge pclk) begin : monitor
      resp_t e;
      if (presetn) begin
         if (penable) check_output("penable_needs_psel", {31'd0, psel}, 32'd1);
         if (req_done != 2'b00) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("[TB] FAIL unexpected_done: got done=%b, expected none", req_done);
            end else begin
               e = exp_q.pop_front();
               check_output("done_pattern", {30'd0, req_done}, {30'd0, e.done});
               check_output("rdata", {24'd0, req_rdata}, {24'd0, e.rdata});
               check_output("err", {31'd0, req_err}, {31'd0, e.err});
            end
         end
      end
   end

   task automatic wait_done(input int r, input bit drop_early);
      bit seen = 1'b0;
      for (int c = 1; c <= 100 && !seen; c++) begin
         @(negedge pclk);
         if (req_done[r]) seen = 1'b1;
         else if (drop_early && c == 1) req_valid[r] = 1'b0;
      end
      req_valid[r] = 1'b0;
      if (!seen) begin
         tests++;
         fails++;
         $display("[TB] FAIL done_timeout: got no req_done[%0d], expected one within 100 cycles", r);
      end
      @(negedge pclk);
   endtask

   task automatic apply_stimulus(input int r, input bit wr, input logic [31:0] addr,
                                 input logic [7:0] wd, input int wt, input bit se,
                                 input bit drop_early);
      plan_wait = wt;
      plan_err  = se;
      exp_q.push_back(predict(r, wr, addr, wd, wt, se));
      req_write[r]          = wr;
      req_addr[r*32 +: 32]  = addr;
      req_wdata[r*8 +: 8]   = wd;
      req_valid[r]          = 1'b1;
      wait_done(r, drop_early);
   endtask

   task automatic do_reset();
      presetn   = 1'b0;
      req_valid = 2'b00;
      repeat (2) @(negedge pclk);
      presetn = 1'b1;
      @(negedge pclk);
   endtask

   initial begin
      int ndone;
      int acc;
      bit quiet;
      presetn   = 1'b0;
      req_valid = 2'b00;
      req_write = 2'b00;
      req_addr  = '0;
      req_wdata = '0;
      prdata    = 8'h00;
      pready    = 1'b0;
      pslverr   = 1'b0;
      for (int i = 0; i < 16; i++) begin
         slave_mem[i] = 8'(i * 17 + 3);
         ref_mem[i]   = 8'(i * 17 + 3);
      end

      // Outputs while reset is held.
      repeat (2) @(negedge pclk);
      check_output("rst_psel", {31'd0, psel}, 32'd0);
      check_output("rst_penable", {31'd0, penable}, 32'd0);
      check_output("rst_pwrite", {31'd0, pwrite}, 32'd0);
      check_output("rst_paddr", paddr, 32'd0);
      check_output("rst_pwdata", {24'd0, pwdata}, 32'd0);
      check_output("rst_done", {30'd0, req_done}, 32'd0);
      check_output("rst_rdata", {24'd0, req_rdata}, 32'd0);
      check_output("rst_err", {31'd0, req_err}, 32'd0);
      presetn = 1'b1;
      @(negedge pclk);

      // Requester 0 writes 0xA5 to address 3 with a zero-wait slave.
      plan_wait = 0;
      plan_err  = 1'b0;
      exp_q.push_back(predict(0, 1'b1, 32'd3, 8'hA5, 0, 1'b0));
      req_write[0]     = 1'b1;
      req_addr[31:0]   = 32'd3;
      req_wdata[7:0]   = 8'hA5;
      req_valid[0]     = 1'b1;
      @(negedge pclk);
      check_output("k1_psel", {31'd0, psel}, 32'd1);
      check_output("k1_penable", {31'd0, penable}, 32'd0);
      @(negedge pclk);
      check_output("k2_penable", {31'd0, penable}, 32'd1);
      check_output("k2_paddr", paddr, 32'd3);
      check_output("k2_pwdata", {24'd0, pwdata}, 32'h0000_00A5);
      check_output("k2_pwrite", {31'd0, pwrite}, 32'd1);
      @(negedge pclk);
      check_output("k3_done", {30'd0, req_done}, 32'd1);
      check_output("k3_psel", {31'd0, psel}, 32'd0);
      req_valid[0] = 1'b0;
      @(negedge pclk);

      // Requester 1 reads the byte just written.
      apply_stimulus(1, 1'b0, 32'd3, 8'h00, 0, 1'b0, 1'b0);
      check_output("readback_a5", {24'd0, req_rdata}, 32'h0000_00A5);

      // Illegal address: no bus cycle, error completion right after the grant edge.
      exp_q.push_back(predict(0, 1'b0, 32'd20, 8'h00, 0, 1'b0));
      req_write[0]   = 1'b0;
      req_addr[31:0] = 32'd20;
      req_valid[0]   = 1'b1;
      @(negedge pclk);
      check_output("badaddr_done", {30'd0, req_done}, 32'd1);
      check_output("badaddr_psel", {31'd0, psel}, 32'd0);
      req_valid[0] = 1'b0;
      @(negedge pclk);
      check_output("badaddr_psel_after", {31'd0, psel}, 32'd0);

      // Slave never answers: exactly TIMEOUT ACCESS cycles then an error.
      plan_wait = TIMEOUT + 4;
      plan_err  = 1'b0;
      exp_q.push_back(predict(1, 1'b0, 32'd5, 8'h00, TIMEOUT + 4, 1'b0));
      req_write[1]    = 1'b0;
      req_addr[63:32] = 32'd5;
      req_valid[1]    = 1'b1;
      acc = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge pclk);
         if (penable) acc++;
         if (req_done[1]) break;
      end
      req_valid[1] = 1'b0;
      check_output("timeout_access_cycles", 32'(acc), 32'(TIMEOUT));
      @(negedge pclk);

      // A request raised and dropped while busy is cancelled without effect.
      plan_wait = 5;
      plan_err  = 1'b0;
      exp_q.push_back(predict(0, 1'b0, 32'd2, 8'h00, 5, 1'b0));
      req_write[0]   = 1'b0;
      req_addr[31:0] = 32'd2;
      req_valid[0]   = 1'b1;
      repeat (3) @(negedge pclk);
      req_write[1]    = 1'b1;
      req_addr[63:32] = 32'd6;
      req_wdata[15:8] = 8'h3C;
      req_valid[1]    = 1'b1;
      repeat (2) @(negedge pclk);
      req_valid[1] = 1'b0;
      wait_done(0, 1'b0);
      quiet = 1'b1;
      repeat (4) begin
         @(negedge pclk);
         if (psel || (req_done != 2'b00)) quiet = 1'b0;
      end
      check_output("cancel_quiet", {31'd0, quiet}, 32'd1);
      apply_stimulus(1, 1'b0, 32'd6, 8'h00, 0, 1'b0, 1'b0);

      // Both requesters held: grants alternate 0,1,0,1 from a fresh reset.
      do_reset();
      plan_wait = 0;
      plan_err  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(predict(i % 2, 1'b0, (i % 2 == 0) ? 32'd3 : 32'd7, 8'h00, 0, 1'b0));
      end
      req_write = 2'b00;
      req_addr  = {32'd7, 32'd3};
      req_valid = 2'b11;
      ndone = 0;
      for (int c = 0; c < 40 && ndone < 4; c++) begin
         @(negedge pclk);
         if (req_done != 2'b00) ndone++;
      end
      req_valid = 2'b00;
      check_output("rr_transfers", 32'(ndone), 32'd4);
      @(negedge pclk);

      // Reset in ACCESS: outputs clear at once, no completion, pointer back to 0.
      plan_wait = 40;
      req_write[0]   = 1'b0;
      req_addr[31:0] = 32'd1;
      req_valid[0]   = 1'b1;
      repeat (3) @(negedge pclk);
      check_output("abort_in_access", {31'd0, penable}, 32'd1);
      #2;
      presetn   = 1'b0;
      req_valid = 2'b00;
      #1;
      check_output("abort_psel", {31'd0, psel}, 32'd0);
      check_output("abort_penable", {31'd0, penable}, 32'd0);
      check_output("abort_paddr", paddr, 32'd0);
      check_output("abort_done", {30'd0, req_done}, 32'd0);
      @(negedge pclk);
      check_output("abort_no_done", {30'd0, req_done}, 32'd0);
      @(negedge pclk);
      presetn   = 1'b1;
      plan_wait = 0;
      exp_q.push_back(predict(0, 1'b0, 32'd4, 8'h00, 0, 1'b0));
      req_write = 2'b00;
      req_addr  = {32'd9, 32'd4};
      req_valid = 2'b11;
      ndone = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge pclk);
         if (req_done != 2'b00) begin
            check_output("post_reset_grant", {30'd0, req_done}, 32'd1);
            ndone = 1;
            break;
         end
      end
      req_valid = 2'b00;
      check_output("post_reset_done_seen", 32'(ndone), 32'd1);
      @(negedge pclk);

      // Random traffic from either requester.
      for (int n = 0; n < 40; n++) begin
         int          r;
         bit          wr;
         logic [31:0] addr;
         int          wt;
         r    = $urandom_range(0, 1);
         wr   = 1'($urandom_range(0, 1));
         addr = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(16, 40)) : 32'($urandom_range(0, 15));
         wt   = ($urandom_range(0, 9) == 0) ? TIMEOUT + $urandom_range(0, 3) : $urandom_range(0, 3);
         apply_stimulus(r, wr, addr, 8'($urandom), wt, ($urandom_range(0, 7) == 0),
                        1'($urandom_range(0, 1)));
      end

      repeat (3) @(negedge pclk);
      check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
